// File: rtl/vga_cap_pkg.sv
// Shared state encoding, default sizes and a width helper for the video line capture block.
package vga_cap_pkg;

    localparam int DEF_ROW_WIDTH      = 320;
    localparam int DEF_INDEX_W        = 8;
    localparam int DEF_PRE_SYNC_LINES = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_SKIP,
        ST_OFFSET,
        ST_CAPTURE,
        ST_WAIT_H
    } cap_state_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Single register stage on the raw video inputs plus one-cycle rise/fall pulses for the syncs.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync_i,
    input  logic hsync_i,
    input  logic video_i,
    output logic vsync_o,
    output logic video_o,
    output logic vs_rise_o,
    output logic vs_fall_o,
    output logic hs_rise_o,
    output logic hs_fall_o
);
    logic vs_q, hs_q, vid_q, vs_prev_q, hs_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            vid_q     <= 1'b0;
            vs_prev_q <= 1'b0;
            hs_prev_q <= 1'b0;
        end else begin
            vs_q      <= vsync_i;
            hs_q      <= hsync_i;
            vid_q     <= video_i;
            vs_prev_q <= vs_q;
            hs_prev_q <= hs_q;
        end
    end

    assign vsync_o   = vs_q;
    assign video_o   = vid_q;
    assign vs_rise_o =  vs_q & ~vs_prev_q;
    assign vs_fall_o = ~vs_q &  vs_prev_q;
    assign hs_rise_o =  hs_q & ~hs_prev_q;
    assign hs_fall_o = ~hs_q &  hs_prev_q;

endmodule

// File: rtl/video_line_capture.sv
// Captures one bit per pixel of each active video line into a row register with a valid/ready output.
// Optional pixel decimation is compiled in with VGA_CAP_DECIM_EN.
module video_line_capture
    import vga_cap_pkg::*;
#(
    parameter int ROW_WIDTH      = DEF_ROW_WIDTH,
    parameter int INDEX_W        = DEF_INDEX_W,
    parameter int PRE_SYNC_LINES = DEF_PRE_SYNC_LINES,
    parameter int H_OFFSET       = 0,
    parameter int DECIM          = 1
) (
    input  logic                 pixel_clk,
    input  logic                 rst,
    input  logic                 in_vsync,
    input  logic                 in_hsync,
    input  logic                 in_video,
    output logic [ROW_WIDTH-1:0] row_data,
    output logic [INDEX_W-1:0]   row_index,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 frame_start,
    output logic                 overflow
);
    localparam int CW = cnt_w(ROW_WIDTH);
    localparam int LW = cnt_w(PRE_SYNC_LINES + 1);
    localparam int OW = cnt_w(H_OFFSET);
    localparam logic [OW-1:0] OFF_LAST   = (H_OFFSET > 0) ? OW'(H_OFFSET - 1) : '0;
    localparam cap_state_e    LINE_START = (H_OFFSET > 0) ? ST_OFFSET : ST_CAPTURE;

    if (DECIM < 1) begin : g_bad_decim
        $error("DECIM must be at least 1");
    end

    logic vs, vid, vs_rise, vs_fall, hs_rise, hs_fall;

    sync_edge_detect u_sync (
        .clk_i     (pixel_clk),
        .rst_i     (rst),
        .vsync_i   (in_vsync),
        .hsync_i   (in_hsync),
        .video_i   (in_video),
        .vsync_o   (vs),
        .video_o   (vid),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hs_rise_o (hs_rise),
        .hs_fall_o (hs_fall)
    );

    cap_state_e           state_q, state_d;
    logic [LW-1:0]        lines_q;
    logic [OW-1:0]        off_q;
    logic [CW-1:0]        col_q;
    logic [ROW_WIDTH-1:0] buf_q;
    logic [INDEX_W-1:0]   idx_q;
    logic                 done_q, row_done, keep;
    logic [ROW_WIDTH-1:0] row_data_q;
    logic [INDEX_W-1:0]   row_index_q;
    logic                 row_valid_q, overflow_q;

`ifdef VGA_CAP_DECIM_EN
    localparam int DW = cnt_w(DECIM);
    logic [DW-1:0] dcnt_q;

    // Phase 0 is the first pixel after the offset, then every DECIM-th cycle.
    always_ff @(posedge pixel_clk) begin
        if (rst || state_q != ST_CAPTURE)  dcnt_q <= '0;
        else if (dcnt_q == DW'(DECIM - 1)) dcnt_q <= '0;
        else                               dcnt_q <= dcnt_q + 1'b1;
    end

    assign keep = (state_q == ST_CAPTURE) && (dcnt_q == '0);
`else
    assign keep = (state_q == ST_CAPTURE);
`endif

    always_ff @(posedge pixel_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        row_done = 1'b0;
        case (state_q)
            ST_IDLE:    if (vs_fall) state_d = ST_VBLANK;
            ST_VBLANK:  if (vs_rise) state_d = ST_SKIP;
            ST_SKIP:    if (hs_fall && lines_q == '0) state_d = LINE_START;
            ST_OFFSET:  if (off_q == OFF_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: if (hs_rise || (keep && col_q == CW'(ROW_WIDTH - 1))) begin
                            state_d  = ST_WAIT_H;
                            row_done = 1'b1;
                        end
            ST_WAIT_H:  if (hs_fall) state_d = LINE_START;
            default:    state_d = ST_IDLE;
        endcase
        // IDLE waits for a real falling edge so a frame after reset always sees a full vsync.
        if (state_q != ST_IDLE && !vs) begin
            state_d  = ST_VBLANK;
            row_done = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            lines_q <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= row_done;
            off_q  <= (state_q == ST_OFFSET) ? off_q + 1'b1 : '0;
            if (state_d == ST_VBLANK) begin
                lines_q <= LW'(PRE_SYNC_LINES);
                idx_q   <= '0;
            end else begin
                if (state_q == ST_SKIP && hs_fall && lines_q != '0) lines_q <= lines_q - 1'b1;
                if (state_q == ST_WAIT_H && hs_fall)                idx_q   <= idx_q + 1'b1;
            end
            // The buffer survives the completion cycle so the output stage can copy it.
            if (state_q != ST_CAPTURE) begin
                col_q <= '0;
                buf_q <= '0;
            end else if (keep && !hs_rise) begin
                buf_q[col_q] <= vid;
                col_q        <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            row_data_q  <= '0;
            row_index_q <= '0;
            row_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (done_q) begin
                if (!row_valid_q || row_ready) begin
                    row_data_q  <= buf_q;
                    row_index_q <= idx_q;
                    row_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (row_ready) begin
                row_valid_q <= 1'b0;
            end
        end
    end

    assign row_data    = row_data_q;
    assign row_index   = row_index_q;
    assign row_valid   = row_valid_q;
    assign overflow    = overflow_q;
    assign frame_start = vs_fall;

endmodule

// File: tb/tb_video_line_capture.sv
// Randomized self-checking bench for video_line_capture with a line-level reference model.
module tb_video_line_capture;
    localparam int RW   = 320;
    localparam int IW   = 8;
    localparam int PRE  = 12;
    localparam int HOFF = 2;
`ifdef VGA_CAP_DECIM_EN
    localparam int DEC = 2;
`else
    localparam int DEC = 1;
`endif

    logic pixel_clk = 1'b0;
    logic rst = 1'b1, in_vsync = 1'b1, in_hsync = 1'b1, in_video = 1'b0, row_ready = 1'b1;
    logic [RW-1:0] row_data;
    logic [IW-1:0] row_index;
    logic row_valid, frame_start, overflow;

    int n_pass = 0, n_tot = 0;
    logic [RW-1:0] got_data[$];
    int got_idx[$];
    int ovf_cnt = 0, fs_cnt = 0, vld_cyc = 0;

    video_line_capture #(.ROW_WIDTH(RW), .INDEX_W(IW), .PRE_SYNC_LINES(PRE),
                         .H_OFFSET(HOFF), .DECIM(DEC)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .in_vsync(in_vsync), .in_hsync(in_hsync),
        .in_video(in_video), .row_data(row_data), .row_index(row_index),
        .row_valid(row_valid), .row_ready(row_ready), .frame_start(frame_start),
        .overflow(overflow));

    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk) begin
        if (row_valid && row_ready) begin
            got_data.push_back(row_data);
            got_idx.push_back(int'(row_index));
        end
        if (overflow)    ovf_cnt++;
        if (frame_start) fs_cnt++;
        if (row_valid)   vld_cyc++;
    end

    task automatic tick();
        @(posedge pixel_clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Expected content of a line cut short after n pixels.
    function automatic logic [RW-1:0] trunc_row(input logic [RW-1:0] r, input int n);
        logic [RW-1:0] m;
        for (int i = 0; i < RW; i++) m[i] = (i < n) ? r[i] : 1'b0;
        return m;
    endfunction

    // vsync pulse followed by PRE short hsync lines that must all be skipped.
    task automatic frame();
        in_hsync = 1'b1; in_vsync = 1'b0; idle(4);
        in_vsync = 1'b1; idle(3);
        for (int l = 0; l < PRE; l++) begin
            in_hsync = 1'b0; idle(3);
            in_hsync = 1'b1; idle(3);
        end
    endtask

    // Pixel n sits HOFF+1+n*DEC cycles after hsync falls; skipped slots carry the inverse.
    task automatic send_line(input logic [RW-1:0] pix, input int n_act, input bit keep_open);
        in_hsync = 1'b0; in_video = 1'($urandom); tick();
        for (int i = 0; i < HOFF; i++) begin in_video = 1'($urandom); tick(); end
        for (int k = 0; k < n_act * DEC; k++) begin
            in_video = (k % DEC == 0) ? pix[k / DEC] : ~pix[k / DEC];
            tick();
        end
        if (!keep_open) begin
            in_hsync = 1'b1; in_video = 1'b1; idle(6);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(3);
        n_tot++; if (row_valid !== 1'b0)  $display("FAIL reset_valid: got %b want 0", row_valid); else n_pass++;
        n_tot++; if (row_data !== '0)     $display("FAIL reset_data: got %h want 0", row_data); else n_pass++;
        n_tot++; if (row_index !== '0)    $display("FAIL reset_index: got %0d want 0", row_index); else n_pass++;
        n_tot++; if (overflow !== 1'b0)   $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        n_tot++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", frame_start); else n_pass++;
        rst = 1'b0; idle(2);
    endtask

    task automatic test_basic();
        logic [RW-1:0] r, d;
        int idx, fs0, ovf0;
        row_ready = 1'b1; got_data.delete(); got_idx.delete();
        fs0 = fs_cnt; ovf0 = ovf_cnt;
        frame();
        for (int i = 0; i < RW; i++) r[i] = (i % 2 == 0);
        for (int l = 0; l < 4; l++) begin
            if (l > 0) r = rand_row();
            send_line(r, RW, 1'b0);
            n_tot++;
            if (got_data.size() != 1) begin
                $display("FAIL basic_count line %0d: got %0d rows want 1", l, got_data.size());
            end else begin
                n_pass++;
                d = got_data.pop_front(); idx = got_idx.pop_front();
                n_tot++; if (d !== r)  $display("FAIL basic_data line %0d: got %h want %h", l, d, r); else n_pass++;
                n_tot++; if (idx != l) $display("FAIL basic_index line %0d: got %0d want %0d", l, idx, l); else n_pass++;
            end
        end
        n_tot++; if (fs_cnt - fs0 != 1)  $display("FAIL basic_frame_start: got %0d pulses want 1", fs_cnt - fs0); else n_pass++;
        n_tot++; if (ovf_cnt != ovf0)    $display("FAIL basic_overflow: got %0d pulses want 0", ovf_cnt - ovf0); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] r0, r;
        int ovf0;
        got_data.delete(); got_idx.delete();
        row_ready = 1'b0; ovf0 = ovf_cnt;
        frame();
        r0 = rand_row(); send_line(r0, RW, 1'b0);
        for (int l = 1; l < 3; l++) begin
            r = rand_row(); send_line(r, RW, 1'b0);
            n_tot++;
            if (row_valid !== 1'b1 || row_data !== r0 || row_index !== '0)
                $display("FAIL bp_hold line %0d: valid %b idx %0d data %h want valid 1 idx 0 data %h",
                         l, row_valid, row_index, row_data, r0);
            else n_pass++;
        end
        n_tot++; if (ovf_cnt - ovf0 != 2)   $display("FAIL bp_overflow: got %0d pulses want 2", ovf_cnt - ovf0); else n_pass++;
        n_tot++; if (got_data.size() != 0)  $display("FAIL bp_no_accept: got %0d rows want 0", got_data.size()); else n_pass++;
        row_ready = 1'b1; tick(); row_ready = 1'b0; idle(3);
        n_tot++;
        if (got_data.size() != 1 || got_data[0] !== r0 || got_idx[0] != 0)
            $display("FAIL bp_accept: got %0d rows want 1 row idx 0 data %h", got_data.size(), r0);
        else n_pass++;
        n_tot++; if (row_valid !== 1'b0) $display("FAIL bp_release: got valid %b want 0", row_valid); else n_pass++;
        got_data.delete(); got_idx.delete();
        row_ready = 1'b1; r = rand_row(); send_line(r, RW, 1'b0);
        n_tot++;
        if (got_data.size() != 1 || got_data[0] !== r || got_idx[0] != 3)
            $display("FAIL bp_index_advance: got %0d rows idx %0d want 1 row idx 3",
                     got_data.size(), (got_idx.size() > 0) ? got_idx[0] : -1);
        else n_pass++;
    endtask

    task automatic test_early();
        logic [RW-1:0] r, d, e;
        int n;
        row_ready = 1'b1; got_data.delete(); got_idx.delete();
        frame();
        for (int l = 0; l < 2; l++) begin
            n = (l == 0) ? 200 : int'($urandom_range(1, RW - 1));
            r = rand_row(); e = trunc_row(r, n);
            send_line(r, n, 1'b0);
            n_tot++;
            if (got_data.size() != 1) begin
                $display("FAIL early_count len %0d: got %0d rows want 1", n, got_data.size());
            end else begin
                n_pass++;
                d = got_data.pop_front();
                n_tot++; if (d !== e) $display("FAIL early_data len %0d: got %h want %h", n, d, e); else n_pass++;
                n_tot++; if (got_idx.pop_front() != l) $display("FAIL early_index len %0d: wrong index want %0d", n, l); else n_pass++;
                if (l == 0) begin
                    n_tot++; if (d[RW-1:200] !== '0) $display("FAIL early_tail_zero: got %h want 0", d[RW-1:200]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_vsync_abort();
        logic [RW-1:0] r0, r1, r2;
        int fs0, ovf0;
        row_ready = 1'b1; got_data.delete(); got_idx.delete();
        frame();
        r0 = rand_row(); send_line(r0, RW, 1'b0);
        fs0 = fs_cnt; ovf0 = ovf_cnt;
        r1 = rand_row(); send_line(r1, 100, 1'b1);
        in_vsync = 1'b0; tick();
        frame();
        n_tot++; if (got_data.size() != 1) $display("FAIL abort_rows: got %0d rows want 1", got_data.size()); else n_pass++;
        n_tot++; if (ovf_cnt != ovf0)      $display("FAIL abort_overflow: got %0d pulses want 0", ovf_cnt - ovf0); else n_pass++;
        n_tot++; if (fs_cnt - fs0 != 1)    $display("FAIL abort_frame_start: got %0d pulses want 1", fs_cnt - fs0); else n_pass++;
        got_data.delete(); got_idx.delete();
        r2 = rand_row(); send_line(r2, RW, 1'b0);
        n_tot++;
        if (got_data.size() != 1 || got_data[0] !== r2 || got_idx[0] != 0)
            $display("FAIL abort_restart: got %0d rows idx %0d want 1 row idx 0",
                     got_data.size(), (got_idx.size() > 0) ? got_idx[0] : -1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [RW-1:0] r;
        int vld0;
        row_ready = 1'b0; got_data.delete(); got_idx.delete();
        frame();
        r = rand_row(); send_line(r, RW, 1'b0);
        r = rand_row(); send_line(r, 50, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        n_tot++; if (row_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", row_valid); else n_pass++;
        n_tot++; if (row_data !== '0)    $display("FAIL rstmid_data: got %h want 0", row_data); else n_pass++;
        n_tot++; if (row_index !== '0)   $display("FAIL rstmid_index: got %0d want 0", row_index); else n_pass++;
        in_hsync = 1'b1; idle(3);
        row_ready = 1'b1; vld0 = vld_cyc;
        for (int l = 0; l < 2; l++) begin r = rand_row(); send_line(r, RW, 1'b0); end
        n_tot++; if (vld_cyc != vld0) $display("FAIL rstmid_idle: got %0d valid cycles want 0", vld_cyc - vld0); else n_pass++;
        frame();
        r = rand_row(); send_line(r, RW, 1'b0);
        n_tot++;
        if (got_data.size() != 1 || got_data[0] !== r || got_idx[0] != 0)
            $display("FAIL rstmid_first_row: got %0d rows want 1 row idx 0", got_data.size());
        else n_pass++;
    endtask

`ifdef VGA_CAP_DECIM_EN
    task automatic test_decim();
        logic [RW-1:0] ones;
        ones = '1;
        row_ready = 1'b1; got_data.delete(); got_idx.delete();
        frame();
        in_hsync = 1'b0; in_video = 1'b0; tick();
        for (int i = 0; i < HOFF; i++) tick();
        for (int k = 0; k < RW * 2; k++) begin in_video = (k % 2 == 0); tick(); end
        in_hsync = 1'b1; in_video = 1'b0; idle(6);
        n_tot++;
        if (got_data.size() != 1 || got_data[0] !== ones)
            $display("FAIL decim_parity: got %0d rows data %h want all ones",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : '0);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_early();
        test_vsync_abort();
        test_reset_mid();
`ifdef VGA_CAP_DECIM_EN
        test_decim();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
